// File: rtl/calc_input_conditioner.sv
// calc_input_conditioner
//   Front end for the 4-bit mini calculator. The 12 raw board inputs (8 switches,
//   4 buttons) are each synchronised through two flops and then debounced.
//   A debounced button rising edge latches both operands from the debounced
//   switches, together with a sticky one-hot operation select. The calculator
//   therefore sees operands that stay stable for the whole operation.
//
// Ports
//   clk       in   1  single clock, all state updates on posedge
//   rst_n     in   1  synchronous reset, active low
//   sw_raw    in   8  raw switches: [7:4] operand a, [3:0] operand b
//   btn_raw   in   4  raw buttons: 0 add/sub, 1 sort, 2 mul, 3 div/mod
//   a         out  4  latched operand a
//   b         out  4  latched operand b
//   btn       out  4  sticky one-hot operation select, 0 = none yet
//   op_valid  out  1  high once any operation has been latched since reset
//   op_pulse  out  1  one-cycle strobe in the cycle a/b/btn take new values
module calc_input_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw_raw,
    input  logic [3:0] btn_raw,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] btn,
    output logic       op_valid,
    output logic       op_pulse
);

    localparam int unsigned NUM_IN = 12;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bits [11:4] are switches, [3:0] are buttons.
    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] s1;
    logic [NUM_IN-1:0] s2;
    logic [NUM_IN-1:0] db;
    logic [NUM_IN-1:0] db_d;
    logic [CNT_W-1:0]  cnt   [NUM_IN];
    logic [CNT_W-1:0]  cnt_d [NUM_IN];

    logic [3:0] btn_db;
    logic [3:0] btn_db_q;
    logic [3:0] rise;
    logic [3:0] sel;
    logic [7:0] sw_db;

    assign raw    = {sw_raw, btn_raw};
    assign btn_db = db[3:0];
    assign sw_db  = db[11:4];
    assign rise   = btn_db & ~btn_db_q;

    // Per-bit debounce: the count only advances while s2 disagrees with db, so
    // any glitch back to the stable level restarts it from zero.
    always_comb begin
        for (int i = 0; i < NUM_IN; i++) begin
            db_d[i]  = db[i];
            cnt_d[i] = '0;
            if (s2[i] != db[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    db_d[i] = s2[i];
                end else begin
                    cnt_d[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Highest-index rising edge wins when several buttons rise together.
    always_comb begin
        sel = 4'b0000;
        if (rise[3]) begin
            sel = 4'b1000;
        end else if (rise[2]) begin
            sel = 4'b0100;
        end else if (rise[1]) begin
            sel = 4'b0010;
        end else if (rise[0]) begin
            sel = 4'b0001;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1       <= '0;
            s2       <= '0;
            db       <= '0;
            btn_db_q <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= '0;
            end
            a        <= '0;
            b        <= '0;
            btn      <= '0;
            op_valid <= 1'b0;
            op_pulse <= 1'b0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            db       <= db_d;
            btn_db_q <= btn_db;
            for (int i = 0; i < NUM_IN; i++) begin
                cnt[i] <= cnt_d[i];
            end
            if (|rise) begin
                a        <= sw_db[7:4];
                b        <= sw_db[3:0];
                btn      <= sel;
                op_valid <= 1'b1;
                op_pulse <= 1'b1;
            end else begin
                op_pulse <= 1'b0;
            end
        end
    end

endmodule
